// File: rtl/ped_pkg.sv
// Shared definitions for the ped64 job scheduler: field width, operating modes,
// mode legality check and scheduler FSM states.
package ped_pkg;

    localparam int FIELD_SIZE = 253;

    localparam logic [2:0] MODE_U8  = 3'b000;
    localparam logic [2:0] MODE_U16 = 3'b001;
    localparam logic [2:0] MODE_U32 = 3'b010;
    localparam logic [2:0] MODE_I8  = 3'b100;
    localparam logic [2:0] MODE_I16 = 3'b101;
    localparam logic [2:0] MODE_I32 = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY
    } sched_state_t;

    function automatic logic mode_legal(input logic [2:0] mode);
        case (mode)
            MODE_U8, MODE_U16, MODE_U32,
            MODE_I8, MODE_I16, MODE_I32: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ped64_sched_if.sv
// Bundle of all scheduler-facing buses: requester fabric, ped64 job/result/leaf
// streams, tagged output streams and status.
interface ped64_sched_if #(
    parameter int NREQ       = 4,
    parameter int INPUT_SIZE = 32,
    parameter int FIELD_SIZE = ped_pkg::FIELD_SIZE,
    parameter int ID_W       = $clog2(NREQ)
) ();

    logic [NREQ-1:0]            i_req_vld;
    logic [NREQ*INPUT_SIZE-1:0] i_req_a;
    logic [NREQ*3-1:0]          i_req_mode;
    logic [NREQ-1:0]            o_req_rdy;

    logic                       o_ped_vld;
    logic [INPUT_SIZE-1:0]      o_ped_a;
    logic [2:0]                 o_ped_mode;
    logic                       i_ped_rdy;

    logic                       i_ped_res_vld;
    logic [FIELD_SIZE-1:0]      i_ped_res;
    logic                       i_ped_last;
    logic                       o_ped_res_rdy;

    logic                       i_ped_lvs_vld;
    logic [FIELD_SIZE-1:0]      i_ped_lvs;
    logic                       o_ped_lvs_rdy;

    logic                       o_res_vld;
    logic [FIELD_SIZE-1:0]      o_res;
    logic                       o_res_last;
    logic [ID_W-1:0]            o_res_id;
    logic                       i_res_rdy;

    logic                       o_lvs_vld;
    logic [FIELD_SIZE-1:0]      o_lvs;
    logic [ID_W-1:0]            o_lvs_id;
    logic                       i_lvs_rdy;

    logic                       o_err_vld;
    logic [ID_W-1:0]            o_err_id;
    logic                       o_busy;
    logic [15:0]                o_job_cnt;

    modport slave (
        input  i_req_vld, i_req_a, i_req_mode,
        output o_req_rdy,
        output o_ped_vld, o_ped_a, o_ped_mode,
        input  i_ped_rdy,
        input  i_ped_res_vld, i_ped_res, i_ped_last,
        output o_ped_res_rdy,
        input  i_ped_lvs_vld, i_ped_lvs,
        output o_ped_lvs_rdy,
        output o_res_vld, o_res, o_res_last, o_res_id,
        input  i_res_rdy,
        output o_lvs_vld, o_lvs, o_lvs_id,
        input  i_lvs_rdy,
        output o_err_vld, o_err_id, o_busy, o_job_cnt
    );

    modport master (
        output i_req_vld, i_req_a, i_req_mode,
        input  o_req_rdy,
        input  o_ped_vld, o_ped_a, o_ped_mode,
        output i_ped_rdy,
        output i_ped_res_vld, i_ped_res, i_ped_last,
        input  o_ped_res_rdy,
        output i_ped_lvs_vld, i_ped_lvs,
        input  o_ped_lvs_rdy,
        input  o_res_vld, o_res, o_res_last, o_res_id,
        output i_res_rdy,
        input  o_lvs_vld, o_lvs, o_lvs_id,
        output i_lvs_rdy,
        input  o_err_vld, o_err_id, o_busy, o_job_cnt
    );

endinterface

// File: rtl/ped_rr_arb.sv
// Combinational round-robin arbiter: the search starts one past ptr_i and wraps,
// producing a one-hot grant plus its encoded index.
module ped_rr_arb #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic found;
    int   k;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        k     = 0;
        for (int off = 1; off <= N; off++) begin
            k = (int'(ptr_i) + off) % N;
            if (!found && req_i[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = IW'(k);
            end
        end
    end

endmodule

// File: rtl/ped64_sched.sv
// Shares one ped64 core among NREQ requesters: round-robin grant, single job in
// flight, owner-tagged pass-through of the result and leaf streams.
module ped64_sched
    import ped_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int INPUT_SIZE = 32
) (
    input logic          i_clk,
    input logic          i_rst,
    ped64_sched_if.slave bus
);

    localparam int ID_W = $clog2(NREQ);

    sched_state_t          state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       owner_q, owner_d;
    logic [INPUT_SIZE-1:0] a_q, a_d;
    logic [2:0]            mode_q, mode_d;
    logic                  ped_vld_q, ped_vld_d;
    logic                  err_vld_q, err_vld_d;
    logic [ID_W-1:0]       err_id_q, err_id_d;
    logic                  busy_q, busy_d;
    logic [15:0]           cnt_q, cnt_d;

    logic [NREQ-1:0]       arb_req;
    logic [NREQ-1:0]       gnt;
    logic [ID_W-1:0]       gnt_idx;
    logic [INPUT_SIZE-1:0] sel_a;
    logic [2:0]            sel_mode;
    logic                  last_hs;

    // Grants are only possible while idle, so masking the requests here also
    // silences o_req_rdy during ISSUE and BUSY.
    assign arb_req = bus.i_req_vld & {NREQ{state_q == IDLE}};

    ped_rr_arb #(.N(NREQ), .IW(ID_W)) u_arb (
        .req_i (arb_req),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign sel_a    = bus.i_req_a[int'(gnt_idx)*INPUT_SIZE +: INPUT_SIZE];
    assign sel_mode = bus.i_req_mode[int'(gnt_idx)*3 +: 3];
    assign last_hs  = bus.i_ped_res_vld & bus.i_res_rdy & bus.i_ped_last;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        a_d       = a_q;
        mode_d    = mode_q;
        ped_vld_d = ped_vld_q;
        err_vld_d = 1'b0;
        err_id_d  = err_id_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    ptr_d   = gnt_idx;
                    owner_d = gnt_idx;
                    a_d     = sel_a;
                    mode_d  = sel_mode;
                    if (mode_legal(sel_mode)) begin
                        state_d   = ISSUE;
                        ped_vld_d = 1'b1;
                    end else begin
                        err_vld_d = 1'b1;
                        err_id_d  = gnt_idx;
                    end
                end
            end
            ISSUE: begin
                if (ped_vld_q && bus.i_ped_rdy) begin
                    state_d   = BUSY;
                    ped_vld_d = 1'b0;
                end
            end
            BUSY: begin
                if (last_hs) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            ptr_q     <= ID_W'(NREQ - 1);
            owner_q   <= '0;
            a_q       <= '0;
            mode_q    <= '0;
            ped_vld_q <= 1'b0;
            err_vld_q <= 1'b0;
            err_id_q  <= '0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            a_q       <= a_d;
            mode_q    <= mode_d;
            ped_vld_q <= ped_vld_d;
            err_vld_q <= err_vld_d;
            err_id_q  <= err_id_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.o_req_rdy     = gnt;
    assign bus.o_ped_vld     = ped_vld_q;
    assign bus.o_ped_a       = a_q;
    assign bus.o_ped_mode    = mode_q;

    // Owner only moves at a grant, so beats draining after last keep their tag.
    assign bus.o_res_vld     = bus.i_ped_res_vld;
    assign bus.o_res         = bus.i_ped_res;
    assign bus.o_res_last    = bus.i_ped_last;
    assign bus.o_res_id      = owner_q;
    assign bus.o_ped_res_rdy = bus.i_res_rdy;

    assign bus.o_lvs_vld     = bus.i_ped_lvs_vld;
    assign bus.o_lvs         = bus.i_ped_lvs;
    assign bus.o_lvs_id      = owner_q;
    assign bus.o_ped_lvs_rdy = bus.i_lvs_rdy;

    assign bus.o_err_vld     = err_vld_q;
    assign bus.o_err_id      = err_id_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_job_cnt     = cnt_q;

endmodule

// File: doc/ped64_sched.md
# ped64_sched

Job scheduler that shares one `ped64` core among `NREQ` independent requesters. It arbitrates requests round-robin, issues one job at a time, and tags the returned leaf (`lvs`) and result (`res`) streams with the owner id. It also rejects illegal modes and counts completed jobs. It sits between the request fabric and the `ped64` instance; `ped64` is reset by the same `i_rst`.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `INPUT_SIZE`, 32, operand width
- `FIELD_SIZE`, 253, result/leaf width
- `ID_W`, `$clog2(NREQ)`, owner-id width
- Clock and reset: one clock; reset is synchronous and active-high.
- `i_clk`  in  1  clock
- `i_rst`  in  1  synchronous active-high reset
- `i_req_vld`  in  NREQ  per-requester job valid; held until its `o_req_rdy` bit is seen
- `i_req_a`  in  NREQ*INPUT_SIZE  packed operands, requester k at `[k*INPUT_SIZE +: INPUT_SIZE]`
- `i_req_mode`  in  NREQ*3  packed modes, requester k at `[k*3 +: 3]`
- `o_req_rdy`  out  NREQ  one-hot accept strobe
- `o_ped_vld`, `o_ped_a` (INPUT_SIZE), `o_ped_mode` (3)  out  job to ped64 `i_vld`/`i_a`/`i_mode`
- `i_ped_rdy`  in  1  ped64 `o_rdy`
- `i_ped_res_vld`, `i_ped_res` (FIELD_SIZE), `i_ped_last`  in  ped64 result stream
- `o_ped_res_rdy`  out  1  to ped64 `i_res_rdy`
- `i_ped_lvs_vld`, `i_ped_lvs` (FIELD_SIZE)  in  ped64 leaf stream
- `o_ped_lvs_rdy`  out  1  to ped64 `i_lvs_rdy`
- `o_res_vld`, `o_res` (FIELD_SIZE), `o_res_last`, `o_res_id` (ID_W)  out  tagged result stream
- `i_res_rdy`  in  1  result sink ready
- `o_lvs_vld`, `o_lvs` (FIELD_SIZE), `o_lvs_id` (ID_W)  out  tagged leaf stream
- `i_lvs_rdy`  in  1  leaf sink ready
- `o_err_vld`  out  1  one-cycle pulse, illegal-mode job rejected
- `o_err_id`  out  ID_W  requester of the rejected job
- `o_busy`  out  1  state ≠ IDLE
- `o_job_cnt`  out  16  completed jobs, wraps

## Operation
- **Legal modes:** 000 U8, 001 U16, 010 U32, 100 I8, 101 I16, 110 I32. Codes 011 and 111 are illegal.
- **FSM states:** IDLE, ISSUE, BUSY.
- **IDLE:**
  - If any `i_req_vld` is high, the round-robin winner g is selected. Search starts at `ptr+1` mod NREQ.
  - `o_req_rdy[g]`=1 combinationally in this cycle. Its operand and mode are captured at the clock edge.
  - `ptr`←g and `owner`←g.
  - Legal mode → ISSUE.
  - Illegal mode → stay IDLE. `o_err_vld`=1 and `o_err_id`=g next cycle. Nothing is issued and `o_job_cnt` is unchanged.
- **ISSUE:**
  - `o_ped_vld`=1 with the captured operand/mode, held stable until `i_ped_rdy`.
  - On `o_ped_vld & i_ped_rdy` → BUSY.
- **BUSY:**
  - No grants are made.
  - The job ends on a handshaked result beat with `i_ped_last`=1. Then → IDLE and `o_job_cnt`+1.
- **Streams:**
  - Both streams are pure pass-through, in every state.
  - `o_res_vld`=`i_ped_res_vld`, `o_ped_res_rdy`=`i_res_rdy`, `o_res_last`=`i_ped_last`.
  - Leaf stream likewise.
  - `o_res_id`=`o_lvs_id`=`owner`. `owner` changes only at a grant, so beats draining after `last` keep the correct tag until the next grant.
- **Arbitration:**
  - Simultaneous requests are served in rotating order. Each requester waits at most NREQ−1 jobs.
  - A requester may drop `i_req_vld` before its grant; it is then skipped.
- **Reset:**
  - State→IDLE, `ptr`=NREQ−1 (so requester 0 wins first), `owner`=0, `o_job_cnt`=0.
  - All registered outputs are 0: `o_ped_vld`, `o_err_vld`, `o_err_id`, `o_busy`.
  - The `o_ped_a`/`o_ped_mode` capture registers are cleared to 0 as well.
  - A reset mid-job drops the job. Requester handshake state is lost, and requesters re-request.

## Timing
- Grant handshake in cycle T. `o_ped_vld` rises at T+1.
- Minimum job overhead: 1 cycle IDLE + 1 cycle ISSUE, plus the ped64 latency.
- Back-to-back: the result beat with last is handshaked in cycle L, IDLE in L+1, and the next grant is possible in L+1.
- `o_req_rdy` is combinational from `i_req_vld`, `ptr` and state. The stream signals are combinational pass-through. All other outputs are registered.
- `o_err_vld` is high exactly one cycle. Back-to-back illegal requests give consecutive pulses.
- `o_job_cnt` increments in the cycle after the last-beat handshake and wraps 0xFFFF→0.

## Structure
- Package `ped_pkg`:
  - `FIELD_SIZE`
  - mode localparams (U8…I32) and the `mode_legal()` function
  - state enum `sched_state_t`
- Sub-module `ped_rr_arb #(N)`:
  - inputs: request vector and `ptr`
  - outputs: one-hot grant and encoded index
  - combinational

## Test plan
- **Single job:** req0 sends a=1692970200, mode 110; the model replies with 3 lvs beats then 1 res beat with last → one `o_req_rdy[0]` pulse, `o_ped_vld` at T+1, all beats carry id 0, `o_job_cnt`=1.
- **Round-robin fairness:** all 4 requesters hold valid → grant order 0,1,2,3,0; no job is granted while BUSY.
- **Illegal mode:** req2 sends mode 011 → `o_err_vld` one cycle with `o_err_id`=2, no `o_ped_vld`, count unchanged; then req3 with a legal mode is issued normally.
- **Backpressure:**
  - `i_ped_rdy` low for 5 cycles → `o_ped_vld`, a and mode held stable.
  - Random `i_res_rdy`/`i_lvs_rdy` → no beat lost or duplicated.
  - The job ends only on the handshaked last beat.
- **Reset mid-BUSY:** `i_rst` asserted for 1 cycle → IDLE, outputs 0, `o_job_cnt`=0; the next grant goes to requester 0.
- **Counter wrap:** preload via 65536 short jobs (or force) → `o_job_cnt` 0xFFFF→0.
